acc_mem_arbiter: RTL

//  Shares the single accelerator port of Data Memory among NUM_ACC accelerator control units.

---
 rtl/acc_arb_pkg.sv | 12 +
 rtl/acc_rr_picker.sv | 28 ++
 rtl/acc_mem_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/acc_arb_pkg.sv
// acc_arb_pkg: shared FSM/op types and width helper for the accelerator memory arbiter
package acc_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    typedef enum logic {ARB_OP_READ, ARB_OP_WRITE} arb_op_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_rr_picker.sv
// acc_rr_picker: combinational request picker, round-robin from ptr+1 or fixed lowest-index
//   req [NUM_ACC] in  : pending requests
//   ptr [IW]      in  : last served client; the search starts one past it
//   any           out : at least one request pending
//   idx [IW]      out : chosen client
//   ACC_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins, ptr ignored)
module acc_rr_picker import acc_arb_pkg::*; #(
    parameter int NUM_ACC = 2,
    localparam int IW = idx_width(NUM_ACC)
) (
    input  logic [NUM_ACC-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               any,
    output logic [IW-1:0]      idx
);
    always_comb begin
        any = |req;
        idx = '0;
`ifdef ACC_ARB_FIXED_PRIO_EN
        for (int k = NUM_ACC - 1; k >= 0; k--)
            idx = req[k] ? IW'(k) : idx;
`else
        // Walk backwards so the client closest after ptr is the last (winning) assignment.
        for (int k = NUM_ACC; k >= 1; k--)
            idx = req[(int'(ptr) + k) % NUM_ACC] ? IW'((int'(ptr) + k) % NUM_ACC) : idx;
`endif
    end
endmodule

// File: rtl/acc_mem_arbiter.sv
// acc_mem_arbiter: shares the accelerator Data Memory port among NUM_ACC clients, one op at a time
//   clk, rst_n            : clock, synchronous active-low reset
//   acc_read_en/addr      : per-client read requests (addr packed i*ADDR_SIZE)
//   acc_write_en/addr/data: per-client write requests (packed per client)
//   acc_read_data         : registered read line, held until the next capture
//   acc_read_valid        : 1-cycle pulse to the served reader
//   acc_write_done        : 1-cycle pulse to the served writer
//   cpu_mem_req           : CPU owns memory; blocks new grants
//   mem_read_*/mem_write_*: memory port (registered strobes, addr, data)
//   ACC_ARB_FIXED_PRIO_EN : fixed priority arbitration instead of round-robin
module acc_mem_arbiter #(
    parameter int NUM_ACC          = 2,
    parameter int ADDR_SIZE        = 16,
    parameter int READ_DATA_SIZE   = 512,
    parameter int WRITE_DATA_SIZE  = 32,
    parameter int MEM_READ_LATENCY = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_ACC-1:0]                 acc_read_en,
    input  logic [NUM_ACC*ADDR_SIZE-1:0]       acc_read_addr,
    input  logic [NUM_ACC-1:0]                 acc_write_en,
    input  logic [NUM_ACC*ADDR_SIZE-1:0]       acc_write_addr,
    input  logic [NUM_ACC*WRITE_DATA_SIZE-1:0] acc_write_data,
    output logic [READ_DATA_SIZE-1:0]          acc_read_data,
    output logic [NUM_ACC-1:0]                 acc_read_valid,
    output logic [NUM_ACC-1:0]                 acc_write_done,
    input  logic                               cpu_mem_req,
    output logic                               mem_read_en,
    output logic [ADDR_SIZE-1:0]               mem_read_addr,
    input  logic [READ_DATA_SIZE-1:0]          mem_read_data,
    output logic                               mem_write_en,
    output logic [ADDR_SIZE-1:0]               mem_write_addr,
    output logic [WRITE_DATA_SIZE-1:0]         mem_write_data
);
    import acc_arb_pkg::*;

    localparam int IW = idx_width(NUM_ACC);
    localparam int CW = idx_width(MEM_READ_LATENCY);

    arb_state_t                 state_q, state_d;
    arb_op_t                    op_q, op_d;
    logic [IW-1:0]              g_q, g_d, rr_ptr_q, rr_ptr_d;
    logic [ADDR_SIZE-1:0]       addr_q, addr_d;
    logic [WRITE_DATA_SIZE-1:0] wdata_q, wdata_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [READ_DATA_SIZE-1:0]  rdata_q, rdata_d;
    logic [NUM_ACC-1:0]         valid_q, valid_d, done_q, done_d;
    logic                       rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [ADDR_SIZE-1:0]       rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [WRITE_DATA_SIZE-1:0] wr_data_q, wr_data_d;
    logic                       pick_any;
    logic [IW-1:0]              pick_idx;
    logic [NUM_ACC-1:0]         g_onehot;

    acc_rr_picker #(.NUM_ACC(NUM_ACC)) u_picker (
        .req (acc_read_en | acc_write_en),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign g_onehot = NUM_ACC'(1) << g_q;

    // Memory strobes and response pulses are computed one cycle early so they
    // come out of flops aligned with the ISSUE and RESP states.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        g_d       = g_q;
        rr_ptr_d  = rr_ptr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        valid_d   = '0;
        done_d    = '0;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        rd_addr_d = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        case (state_q)
            IDLE: if (!cpu_mem_req && pick_any) begin
                g_d       = pick_idx;
                op_d      = acc_read_en[pick_idx] ? ARB_OP_READ : ARB_OP_WRITE;
                addr_d    = (op_d == ARB_OP_READ) ? acc_read_addr[pick_idx*ADDR_SIZE +: ADDR_SIZE]
                                                  : acc_write_addr[pick_idx*ADDR_SIZE +: ADDR_SIZE];
                wdata_d   = acc_write_data[pick_idx*WRITE_DATA_SIZE +: WRITE_DATA_SIZE];
                rd_en_d   = (op_d == ARB_OP_READ);
                wr_en_d   = (op_d == ARB_OP_WRITE);
                rd_addr_d = rd_en_d ? addr_d : '0;
                wr_addr_d = wr_en_d ? addr_d : '0;
                wr_data_d = wr_en_d ? wdata_d : '0;
                state_d   = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                done_d  = (op_q == ARB_OP_WRITE) ? g_onehot : '0;
                state_d = (op_q == ARB_OP_READ) ? WAIT : RESP;
            end
            WAIT: if (cnt_q == CW'(MEM_READ_LATENCY - 1)) begin
                rdata_d = mem_read_data;
                valid_d = g_onehot;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESP: begin
                rr_ptr_d = g_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= ARB_OP_READ;
            g_q       <= '0;
            rr_ptr_q  <= IW'(NUM_ACC - 1);
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            valid_q   <= '0;
            done_q    <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            g_q       <= g_d;
            rr_ptr_q  <= rr_ptr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign acc_read_data  = rdata_q;
    assign acc_read_valid = valid_q;
    assign acc_write_done = done_q;
    assign mem_read_en    = rd_en_q;
    assign mem_read_addr  = rd_addr_q;
    assign mem_write_en   = wr_en_q;
    assign mem_write_addr = wr_addr_q;
    assign mem_write_data = wr_data_q;
endmodule
